// File: rtl/rep_string_sequencer.sv
// Sequencer for REP/REPE/REPNE MOVS/CMPS: issues one element iteration at a
// time, tracks ECX/ESI/EDI and returns the final register values.
module rep_string_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  start_rep,
    input  logic        start_is_cmps,
    input  logic [1:0]  start_size,
    input  logic        start_df,
    input  logic [31:0] start_ecx,
    input  logic [31:0] start_esi,
    input  logic [31:0] start_edi,
    output logic        iter_valid,
    input  logic        iter_ready,
    output logic [31:0] iter_esi,
    output logic [31:0] iter_edi,
    input  logic        res_valid,
    input  logic        res_zf,
    input  logic        abort,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] done_ecx,
    output logic [31:0] done_esi,
    output logic [31:0] done_edi,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ecx_q, ecx_d;
    logic [31:0] esi_q, esi_d;
    logic [31:0] edi_q, edi_d;
    logic [1:0]  rep_q, rep_d;
    logic [1:0]  size_q, size_d;
    logic        cmps_q, cmps_d;
    logic        df_q, df_d;

    logic [31:0] step;
    logic [31:0] esi_nx, edi_nx, ecx_nx;
    logic        term;

    always_comb begin
        step = 32'd4;
        unique case (size_q)
            2'b00:   step = 32'd1;
            2'b01:   step = 32'd2;
            default: step = 32'd4;
        endcase
    end

    assign esi_nx = df_q ? esi_q - step : esi_q + step;
    assign edi_nx = df_q ? edi_q - step : edi_q + step;
    assign ecx_nx = (rep_q != 2'b00) ? ecx_q - 32'd1 : ecx_q;

    // ZF only terminates CMPS; MOVS treats REPE/REPNE as plain REP
    assign term = (rep_q == 2'b00) || (ecx_nx == 32'd0) ||
                  (cmps_q && rep_q == 2'b10 && !res_zf) ||
                  (cmps_q && rep_q == 2'b11 && res_zf);

    always_comb begin
        state_d = state_q;
        ecx_d   = ecx_q;
        esi_d   = esi_q;
        edi_d   = edi_q;
        rep_d   = rep_q;
        size_d  = size_q;
        cmps_d  = cmps_q;
        df_d    = df_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    ecx_d  = start_ecx;
                    esi_d  = start_esi;
                    edi_d  = start_edi;
                    rep_d  = start_rep;
                    size_d = start_size;
                    cmps_d = start_is_cmps;
                    df_d   = start_df;
                    if (start_rep != 2'b00 && start_ecx == 32'd0)
                        state_d = S_DONE;
                    else
                        state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (iter_ready)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (res_valid) begin
                    esi_d   = esi_nx;
                    edi_d   = edi_nx;
                    ecx_d   = ecx_nx;
                    state_d = term ? S_DONE : S_ISSUE;
                end
            end
            S_DONE: begin
                if (done_ready)
                    state_d = S_IDLE;
            end
        endcase
        if (abort && state_q != S_IDLE)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ecx_q   <= '0;
            esi_q   <= '0;
            edi_q   <= '0;
            rep_q   <= '0;
            size_q  <= '0;
            cmps_q  <= 1'b0;
            df_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ecx_q   <= ecx_d;
            esi_q   <= esi_d;
            edi_q   <= edi_d;
            rep_q   <= rep_d;
            size_q  <= size_d;
            cmps_q  <= cmps_d;
            df_q    <= df_d;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign busy        = !start_ready;
    assign iter_valid  = (state_q == S_ISSUE);
    assign done_valid  = (state_q == S_DONE);
    assign iter_esi    = esi_q;
    assign iter_edi    = edi_q;
    assign done_ecx    = ecx_q;
    assign done_esi    = esi_q;
    assign done_edi    = edi_q;

endmodule

// File: tb/tb_rep_string_sequencer.sv
// Self-checking bench for rep_string_sequencer: directed cases plus
// randomized commands checked against an iteration-level reference model.
module tb_rep_string_sequencer;

    logic        clk;
    logic        rst;
    logic        start_valid;
    logic        start_ready;
    logic [1:0]  start_rep;
    logic        start_is_cmps;
    logic [1:0]  start_size;
    logic        start_df;
    logic [31:0] start_ecx, start_esi, start_edi;
    logic        iter_valid, iter_ready;
    logic [31:0] iter_esi, iter_edi;
    logic        res_valid, res_zf, abort;
    logic        done_valid, done_ready;
    logic [31:0] done_ecx, done_esi, done_edi;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_s [0:63];
    logic [31:0] exp_d [0:63];

    logic [1:0]  r_rep, r_sz;
    logic        r_cmps, r_df;
    logic [31:0] r_ecx;

    rep_string_sequencer dut (
        .clk(clk), .rst(rst),
        .start_valid(start_valid), .start_ready(start_ready),
        .start_rep(start_rep), .start_is_cmps(start_is_cmps),
        .start_size(start_size), .start_df(start_df),
        .start_ecx(start_ecx), .start_esi(start_esi), .start_edi(start_edi),
        .iter_valid(iter_valid), .iter_ready(iter_ready),
        .iter_esi(iter_esi), .iter_edi(iter_edi),
        .res_valid(res_valid), .res_zf(res_zf), .abort(abort),
        .done_valid(done_valid), .done_ready(done_ready),
        .done_ecx(done_ecx), .done_esi(done_esi), .done_edi(done_edi),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_start_ready"}, start_ready, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_iter_valid"}, iter_valid, 0);
        check({tag, "_done_valid"}, done_valid, 0);
    endtask

    // bp/lat < 0 selects a random count per step
    task automatic run_cmd(input logic [1:0] rep, input logic cmps,
                           input logic [1:0] sz, input logic df,
                           input logic [31:0] ecx, input logic [31:0] esi,
                           input logic [31:0] edi, input logic [63:0] zfv,
                           input int ibp, input int rlat, input int dbp);
        int n, b;
        logic [31:0] e, s, d, st;
        bit stop;
        st = (sz == 2'b00) ? 32'd1 : (sz == 2'b01) ? 32'd2 : 32'd4;
        e = ecx; s = esi; d = edi; n = 0;
        if (!(rep != 2'b00 && ecx == 32'd0)) begin
            stop = 0;
            while (!stop && n < 64) begin
                exp_s[n] = s;
                exp_d[n] = d;
                s = df ? s - st : s + st;
                d = df ? d - st : d + st;
                if (rep != 2'b00) e = e - 1;
                stop = (rep == 2'b00) || (e == 0) ||
                       (cmps && rep == 2'b10 && !zfv[n]) ||
                       (cmps && rep == 2'b11 && zfv[n]);
                n++;
            end
        end
        check("pre_start_ready", start_ready, 1);
        start_valid = 1; start_rep = rep; start_is_cmps = cmps;
        start_size = sz; start_df = df;
        start_ecx = ecx; start_esi = esi; start_edi = edi;
        tick();
        start_valid = 0;
        check("post_start_busy", busy, 1);
        for (int k = 0; k < n; k++) begin
            b = (ibp < 0) ? int'($urandom_range(0, 3)) : ibp;
            repeat (b) begin
                check("bp_iter_valid", iter_valid, 1);
                check("bp_iter_esi", iter_esi, exp_s[k]);
                check("bp_iter_edi", iter_edi, exp_d[k]);
                check("bp_done_valid", done_valid, 0);
                iter_ready = 0;
                res_valid = 1;
                res_zf = 1'($urandom);
                tick();
            end
            res_valid = 0;
            check("iter_valid", iter_valid, 1);
            check("iter_esi", iter_esi, exp_s[k]);
            check("iter_edi", iter_edi, exp_d[k]);
            iter_ready = 1;
            tick();
            iter_ready = 0;
            b = (rlat < 0) ? int'($urandom_range(0, 2)) : rlat;
            repeat (b) begin
                check("wait_iter_valid", iter_valid, 0);
                check("wait_done_valid", done_valid, 0);
                tick();
            end
            check("res_iter_valid", iter_valid, 0);
            res_valid = 1;
            res_zf = zfv[k];
            tick();
            res_valid = 0;
        end
        check("done_valid", done_valid, 1);
        check("done_iter_valid", iter_valid, 0);
        check("done_ecx", done_ecx, e);
        check("done_esi", done_esi, s);
        check("done_edi", done_edi, d);
        b = (dbp < 0) ? int'($urandom_range(0, 3)) : dbp;
        repeat (b) begin
            done_ready = 0;
            tick();
            check("hold_done_valid", done_valid, 1);
            check("hold_done_ecx", done_ecx, e);
            check("hold_done_esi", done_esi, s);
            check("hold_done_edi", done_edi, d);
        end
        done_ready = 1;
        tick();
        done_ready = 0;
        check_idle_outputs("after_done");
    endtask

    initial begin
        rst = 1; start_valid = 0; start_rep = 0; start_is_cmps = 0;
        start_size = 0; start_df = 0; start_ecx = 0; start_esi = 0;
        start_edi = 0; iter_ready = 0; res_valid = 0; res_zf = 0;
        abort = 0; done_ready = 0;
        repeat (2) tick();
        check_idle_outputs("reset");
        check("reset_iter_esi", iter_esi, 0);
        check("reset_done_ecx", done_ecx, 0);
        rst = 0;
        tick();

        run_cmd(2'b01, 0, 2'b10, 0, 32'd3, 32'h1000, 32'h2000, 64'h0, 0, 0, 0);
        run_cmd(2'b10, 1, 2'b00, 1, 32'd5, 32'h10, 32'h20, 64'h3, -1, -1, -1);
        run_cmd(2'b01, 0, 2'b10, 0, 32'd0, 32'h55, 32'h66, 64'h0, 0, 0, 0);
        run_cmd(2'b00, 0, 2'b01, 0, 32'd0, 32'h300, 32'h400, 64'h0, 0, 0, 0);
        run_cmd(2'b01, 0, 2'b01, 1, 32'd2, 32'h0, 32'h100, 64'h0, 0, 0, 0);
        run_cmd(2'b11, 1, 2'b11, 0, 32'd4, 32'hFFFF_FFF8, 32'h8, 64'h4,
                0, 1, 0);
        run_cmd(2'b01, 0, 2'b10, 0, 32'd2, 32'h4000, 32'h5000, 64'h0, 4, 1, 3);

        for (int i = 0; i < 30; i++) begin
            r_rep  = 2'($urandom_range(0, 3));
            r_sz   = 2'($urandom_range(0, 3));
            r_cmps = 1'($urandom);
            r_df   = 1'($urandom);
            r_ecx  = ($urandom_range(0, 3) == 0) ? 32'd0
                   : 32'($urandom_range(1, 8));
            run_cmd(r_rep, r_cmps, r_sz, r_df, r_ecx, $urandom, $urandom,
                    {$urandom, $urandom}, -1, -1, -1);
        end

        // abort in WAIT wins over a same-cycle result
        start_valid = 1; start_rep = 2'b01; start_is_cmps = 0;
        start_size = 2'b10; start_df = 0; start_ecx = 32'd3;
        start_esi = 32'h700; start_edi = 32'h800;
        tick();
        start_valid = 0;
        iter_ready = 1;
        tick();
        iter_ready = 0;
        res_valid = 1; abort = 1;
        tick();
        res_valid = 0; abort = 0;
        check_idle_outputs("abort");
        tick();
        check_idle_outputs("abort_hold");
        abort = 1;
        tick();
        abort = 0;
        check_idle_outputs("abort_idle");

        // reset in WAIT
        start_valid = 1;
        tick();
        start_valid = 0;
        iter_ready = 1;
        tick();
        iter_ready = 0;
        rst = 1;
        tick();
        check_idle_outputs("rst_wait");
        check("rst_iter_esi", iter_esi, 0);
        check("rst_iter_edi", iter_edi, 0);
        check("rst_done_ecx", done_ecx, 0);
        check("rst_done_esi", done_esi, 0);
        check("rst_done_edi", done_edi, 0);
        rst = 0;
        tick();

        run_cmd(2'b01, 0, 2'b00, 0, 32'd2, 32'h10, 32'h20, 64'h0, 1, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
